// File: rtl/mmcm_drp_pkg.sv
// Shared types and constants for the MMCM DRP reconfiguration controller.
package mmcm_drp_pkg;

    localparam int unsigned DRP_AW           = 7;
    localparam int unsigned DRP_DW           = 16;
    localparam int unsigned DEF_TBL_DEPTH    = 8;
    localparam int unsigned DEF_TBL_AW       = 3;
    localparam int unsigned DEF_DRDY_TIMEOUT = 255;
    localparam int unsigned DEF_LOCK_TIMEOUT = 65535;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_ASSERT_RST = 4'd1,
        ST_RD_REQ     = 4'd2,
        ST_RD_WAIT    = 4'd3,
        ST_WR_REQ     = 4'd4,
        ST_WR_WAIT    = 4'd5,
        ST_NEXT       = 4'd6,
        ST_RELEASE    = 4'd7,
        ST_WAIT_LOCK  = 4'd8,
        ST_FINISH     = 4'd9
    } drp_state_e;

    // One read-modify-write step: register address, keep-mask, new bits.
    typedef struct packed {
        logic [DRP_AW-1:0] addr;
        logic [DRP_DW-1:0] mask;
        logic [DRP_DW-1:0] data;
    } drp_entry_t;

    // Keep current bits where mask is 1, take new data where mask is 0.
    function automatic logic [DRP_DW-1:0] drp_merge(
        input logic [DRP_DW-1:0] cur,
        input logic [DRP_DW-1:0] mask,
        input logic [DRP_DW-1:0] data
    );
        return (cur & mask) | (data & ~mask);
    endfunction

endpackage

// File: rtl/mmcm_drp_tbl.sv
// Register-array table of DRP entries: one synchronous write port, one asynchronous read port.
module mmcm_drp_tbl
    import mmcm_drp_pkg::*;
#(
    parameter int unsigned TBL_DEPTH = DEF_TBL_DEPTH,
    parameter int unsigned TBL_AW    = DEF_TBL_AW
) (
    input  logic              clk,
    input  logic              we,
    input  logic [TBL_AW-1:0] widx,
    input  drp_entry_t        wentry,
    input  logic [TBL_AW-1:0] ridx,
    output drp_entry_t        rentry
);

    drp_entry_t mem [TBL_DEPTH];

    // Table write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we && (32'(widx) < TBL_DEPTH)) begin
            mem[widx] <= wentry;
        end
    end

    assign rentry = (32'(ridx) < TBL_DEPTH) ? mem[ridx] : '0;

endmodule

// File: rtl/mmcm_drp_ctrl.sv
// Runs a loaded table of read-modify-write DRP accesses on the MMCM while holding it in reset,
// then releases reset and waits for lock.
module mmcm_drp_ctrl
    import mmcm_drp_pkg::*;
#(
    parameter int unsigned TBL_DEPTH    = DEF_TBL_DEPTH,
    parameter int unsigned TBL_AW       = DEF_TBL_AW,
    parameter int unsigned DRDY_TIMEOUT = DEF_DRDY_TIMEOUT,
    parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cfg_we,
    input  logic [TBL_AW-1:0] cfg_idx,
    input  logic [DRP_AW-1:0] cfg_addr,
    input  logic [DRP_DW-1:0] cfg_mask,
    input  logic [DRP_DW-1:0] cfg_data,
    input  logic [TBL_AW:0]   cfg_count,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mmcm_rst,
    output logic [DRP_AW-1:0] daddr,
    output logic              den,
    output logic              dwe,
    output logic [DRP_DW-1:0] di,
    input  logic [DRP_DW-1:0] drp_do,
    input  logic              drdy,
    input  logic              mmcm_locked
);

    localparam int unsigned CNT_W  = TBL_AW + 1;
    localparam int unsigned DCNT_W = $clog2(DRDY_TIMEOUT + 1);
    localparam int unsigned LCNT_W = $clog2(LOCK_TIMEOUT + 1);

    drp_state_e        state_q, state_nxt;
    logic [TBL_AW-1:0] idx_q, idx_nxt;
    logic [CNT_W-1:0]  count_q, count_nxt;
    logic [DCNT_W-1:0] dcnt_q, dcnt_nxt;
    logic [LCNT_W-1:0] lcnt_q, lcnt_nxt;

    logic              count_ok, accept, reject, last_entry, drdy_tmo, lock_tmo;
    logic              tbl_we;
    drp_entry_t        wr_entry, rd_entry;

    logic              busy_d, done_d, err_d, mmcm_rst_d, den_d, dwe_d;
    logic [DRP_AW-1:0] daddr_d;
    logic [DRP_DW-1:0] di_d;

    assign tbl_we   = cfg_we && (state_q == ST_IDLE);
    assign wr_entry = '{addr: cfg_addr, mask: cfg_mask, data: cfg_data};

    // Read port follows the next index so daddr and di can be registered with their state.
    mmcm_drp_tbl #(
        .TBL_DEPTH (TBL_DEPTH),
        .TBL_AW    (TBL_AW)
    ) u_tbl (
        .clk    (clk_in),
        .we     (tbl_we),
        .widx   (cfg_idx),
        .wentry (wr_entry),
        .ridx   (idx_nxt),
        .rentry (rd_entry)
    );

    assign count_ok   = (cfg_count != '0) && (cfg_count <= CNT_W'(TBL_DEPTH));
    assign accept     = (state_q == ST_IDLE) && start && count_ok;
    assign reject     = (state_q == ST_IDLE) && start && !count_ok;
    assign last_entry = ({1'b0, idx_q} == (count_q - CNT_W'(1)));
    assign drdy_tmo   = ((state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT)) && !drdy
                        && (dcnt_q == DCNT_W'(DRDY_TIMEOUT - 1));
    assign lock_tmo   = (state_q == ST_WAIT_LOCK) && !mmcm_locked
                        && (lcnt_q == LCNT_W'(LOCK_TIMEOUT - 1));

    // State register and sequencing counters.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            count_q <= '0;
            dcnt_q  <= '0;
            lcnt_q  <= '0;
        end else begin
            state_q <= state_nxt;
            idx_q   <= idx_nxt;
            count_q <= count_nxt;
            dcnt_q  <= dcnt_nxt;
            lcnt_q  <= lcnt_nxt;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_nxt = state_q;
        idx_nxt   = idx_q;
        count_nxt = count_q;
        dcnt_nxt  = dcnt_q;
        lcnt_nxt  = lcnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    count_nxt = cfg_count;
                    idx_nxt   = '0;
                    state_nxt = ST_ASSERT_RST;
                end
            end
            ST_ASSERT_RST: state_nxt = ST_RD_REQ;
            ST_RD_REQ: begin
                dcnt_nxt  = '0;
                state_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (drdy) begin
                    state_nxt = ST_WR_REQ;
                end else if (drdy_tmo) begin
                    idx_nxt   = '0;
                    state_nxt = ST_RELEASE;
                end else begin
                    dcnt_nxt = dcnt_q + DCNT_W'(1);
                end
            end
            ST_WR_REQ: begin
                dcnt_nxt  = '0;
                state_nxt = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (drdy) begin
                    state_nxt = ST_NEXT;
                end else if (drdy_tmo) begin
                    idx_nxt   = '0;
                    state_nxt = ST_RELEASE;
                end else begin
                    dcnt_nxt = dcnt_q + DCNT_W'(1);
                end
            end
            ST_NEXT: begin
                if (last_entry) begin
                    idx_nxt   = '0;
                    state_nxt = ST_RELEASE;
                end else begin
                    idx_nxt   = idx_q + TBL_AW'(1);
                    state_nxt = ST_RD_REQ;
                end
            end
            ST_RELEASE: begin
                lcnt_nxt  = '0;
                state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (mmcm_locked || lock_tmo) begin
                    state_nxt = ST_FINISH;
                end else begin
                    lcnt_nxt = lcnt_q + LCNT_W'(1);
                end
            end
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the next state, so every output is registered alongside its state.
    always_comb begin
        busy_d     = 1'b0;
        done_d     = 1'b0;
        mmcm_rst_d = 1'b0;
        den_d      = 1'b0;
        dwe_d      = 1'b0;
        err_d      = err;
        daddr_d    = daddr;
        di_d       = di;

        busy_d     = (state_nxt != ST_IDLE);
        done_d     = (state_nxt == ST_FINISH) || reject;
        mmcm_rst_d = state_nxt inside {ST_ASSERT_RST, ST_RD_REQ, ST_RD_WAIT,
                                       ST_WR_REQ, ST_WR_WAIT, ST_NEXT};
        den_d      = (state_nxt == ST_RD_REQ) || (state_nxt == ST_WR_REQ);
        dwe_d      = (state_nxt == ST_WR_REQ);

        if (state_nxt == ST_RD_REQ) begin
            daddr_d = rd_entry.addr;
        end
        // Read data is merged as it arrives; di holds it through the write.
        if ((state_q == ST_RD_WAIT) && drdy) begin
            di_d = drp_merge(drp_do, rd_entry.mask, rd_entry.data);
        end

        if (accept) begin
            err_d = 1'b0;
        end
        if (reject || drdy_tmo || lock_tmo) begin
            err_d = 1'b1;
        end
    end

    // Output registers; mmcm_rst drops asynchronously with rst_n.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            mmcm_rst <= 1'b0;
            den      <= 1'b0;
            dwe      <= 1'b0;
            daddr    <= '0;
            di       <= '0;
        end else begin
            busy     <= busy_d;
            done     <= done_d;
            err      <= err_d;
            mmcm_rst <= mmcm_rst_d;
            den      <= den_d;
            dwe      <= dwe_d;
            daddr    <= daddr_d;
            di       <= di_d;
        end
    end

endmodule

// File: tb/tb_mmcm_drp_ctrl.sv
// Self-checking bench: behavioural DRP/MMCM model plus a transaction-level reference of the table run.
module tb_mmcm_drp_ctrl;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned AW      = 3;
    localparam int unsigned DRDY_TO = 255;
    localparam int unsigned LOCK_TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic [6:0]  cfg_addr;
    logic [15:0] cfg_mask;
    logic [15:0] cfg_data;
    logic [3:0]  cfg_count;
    logic        busy, done, err, mmcm_rst, den, dwe;
    logic [6:0]  daddr;
    logic [15:0] di;
    logic [15:0] drp_do;
    logic        drdy;
    logic        mmcm_locked;

    always #5 clk = ~clk;

    mmcm_drp_ctrl #(
        .TBL_DEPTH    (DEPTH),
        .TBL_AW       (AW),
        .DRDY_TIMEOUT (DRDY_TO),
        .LOCK_TIMEOUT (LOCK_TO)
    ) dut (
        .clk_in      (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_addr    (cfg_addr),
        .cfg_mask    (cfg_mask),
        .cfg_data    (cfg_data),
        .cfg_count   (cfg_count),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .mmcm_rst    (mmcm_rst),
        .daddr       (daddr),
        .den         (den),
        .dwe         (dwe),
        .di          (di),
        .drp_do      (drp_do),
        .drdy        (drdy),
        .mmcm_locked (mmcm_locked)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Shadow of what the host loaded into the table.
    logic [6:0]  t_addr [DEPTH];
    logic [15:0] t_mask [DEPTH];
    logic [15:0] t_data [DEPTH];

    // DRP register file and MMCM behaviour.
    logic [15:0] drp_mem [128];
    logic [6:0]  rd_log [$];
    logic [22:0] wr_log [$];
    int          lat_cfg = 2;
    int          hang_cfg = -1;
    int          lock_cfg = 3;
    int          pend = 0;
    int          lk = 0;
    int          proto_err = 0;
    int          rel_cyc = -1;
    bit          rst_prev = 1'b0;
    logic [15:0] rsp = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            pend        = 0;
            drdy        = 1'b0;
            mmcm_locked = 1'b0;
            lk          = 0;
            rst_prev    = 1'b0;
        end else begin
            drdy   = 1'b0;
            drp_do = 16'($urandom);
            if (den) begin
                if (pend != 0) proto_err++;
                if (!mmcm_rst) proto_err++;
                if (dwe) begin
                    wr_log.push_back({daddr, di});
                    drp_mem[daddr] = di;
                    rsp  = 16'($urandom);
                    pend = lat_cfg;
                end else begin
                    rsp  = drp_mem[daddr];
                    pend = (rd_log.size() == hang_cfg) ? 0 : lat_cfg;
                    rd_log.push_back(daddr);
                end
            end else if (pend != 0) begin
                pend--;
                if (pend == 0) begin
                    drdy   = 1'b1;
                    drp_do = rsp;
                end
            end
            if (mmcm_rst) begin
                lk          = 0;
                mmcm_locked = 1'b0;
            end else begin
                lk++;
                mmcm_locked = (lock_cfg > 0) && (lk > lock_cfg);
            end
            if (rst_prev && !mmcm_rst) rel_cyc = cyc;
            rst_prev = mmcm_rst;
        end
    end

    task automatic load_entry(input int i, input logic [6:0] a, input logic [15:0] m,
                              input logic [15:0] d);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_idx  = 3'(i);
        cfg_addr = a;
        cfg_mask = m;
        cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
        t_addr[i] = a;
        t_mask[i] = m;
        t_data[i] = d;
    endtask

    // Start a run of n entries and compare transactions, timing and err against the reference.
    task automatic run_seq(input string tag, input int n, input int lat, input int hang,
                           input int lockd, input bit poke);
        logic [15:0] pm [128];
        logic [6:0]  exp_rd [$];
        logic [22:0] exp_wr [$];
        logic [15:0] nv;
        int          ent, s, rel_off, done_off, got_done;
        bit          stop, exp_err;

        for (int a = 0; a < 128; a++) pm[a] = drp_mem[a];
        ent  = n;
        stop = 1'b0;
        for (int i = 0; i < n && !stop; i++) begin
            exp_rd.push_back(t_addr[i]);
            if (i == hang) begin
                ent  = i;
                stop = 1'b1;
            end else begin
                nv = (pm[t_addr[i]] & t_mask[i]) | (t_data[i] & ~t_mask[i]);
                pm[t_addr[i]] = nv;
                exp_wr.push_back({t_addr[i], nv});
            end
        end
        exp_err  = stop || (lockd == 0);
        rel_off  = 2 + ent * (2 * lat + 3) + (stop ? 1 + int'(DRDY_TO) : 0);
        done_off = rel_off + ((lockd > 0) ? lockd : int'(LOCK_TO)) + 1;

        lat_cfg  = lat;
        hang_cfg = hang;
        lock_cfg = lockd;
        rd_log.delete();
        wr_log.delete();
        proto_err = 0;
        rel_cyc   = -1;

        @(negedge clk);
        start     = 1'b1;
        cfg_count = 4'(n);
        s         = cyc;
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("%s_rst_on", tag), 32'(mmcm_rst), 32'd1);
        chk($sformatf("%s_busy", tag), 32'(busy), 32'd1);
        chk($sformatf("%s_err_clr", tag), 32'(err), 32'd0);
        if (poke) begin
            @(negedge clk);
            start    = 1'b1;
            cfg_we   = 1'b1;
            cfg_idx  = 3'd0;
            cfg_addr = 7'h7F;
            cfg_mask = 16'h0000;
            cfg_data = 16'h1234;
            @(negedge clk);
            start  = 1'b0;
            cfg_we = 1'b0;
        end

        got_done = -1;
        for (int k = 0; k < 3000 && got_done < 0; k++) begin
            @(negedge clk);
            if (done) got_done = cyc;
        end
        chk($sformatf("%s_done_lat", tag), 32'(got_done - s), 32'(done_off));
        chk($sformatf("%s_rel_lat", tag), 32'(rel_cyc - s), 32'(rel_off));
        chk($sformatf("%s_err", tag), 32'(err), 32'(exp_err));
        chk($sformatf("%s_proto", tag), 32'(proto_err), 32'd0);
        chk($sformatf("%s_nrd", tag), 32'(rd_log.size()), 32'(exp_rd.size()));
        chk($sformatf("%s_nwr", tag), 32'(wr_log.size()), 32'(exp_wr.size()));
        foreach (exp_rd[i])
            chk($sformatf("%s_rd%0d", tag, i),
                (i < rd_log.size()) ? 32'(rd_log[i]) : 32'hDEADBEEF, 32'(exp_rd[i]));
        foreach (exp_wr[i])
            chk($sformatf("%s_wr%0d", tag, i),
                (i < wr_log.size()) ? 32'(wr_log[i]) : 32'hDEADBEEF, 32'(exp_wr[i]));
        @(negedge clk);
        chk($sformatf("%s_done_pulse", tag), 32'(done), 32'd0);
        chk($sformatf("%s_idle", tag), 32'(busy), 32'd0);
    endtask

    // Out-of-range count: immediate done with err, no DRP traffic.
    task automatic bad_start(input string tag, input int cnt);
        rd_log.delete();
        wr_log.delete();
        @(negedge clk);
        start     = 1'b1;
        cfg_count = 4'(cnt);
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("%s_done", tag), 32'(done), 32'd1);
        chk($sformatf("%s_err", tag), 32'(err), 32'd1);
        chk($sformatf("%s_busy", tag), 32'(busy), 32'd0);
        chk($sformatf("%s_rst", tag), 32'(mmcm_rst), 32'd0);
        @(negedge clk);
        chk($sformatf("%s_done_off", tag), 32'(done), 32'd0);
        chk($sformatf("%s_no_den", tag), 32'(rd_log.size() + wr_log.size()), 32'd0);
    endtask

    initial begin
        int n, got;
        rst_n       = 1'b0;
        start       = 1'b0;
        cfg_we      = 1'b0;
        cfg_idx     = '0;
        cfg_addr    = '0;
        cfg_mask    = '0;
        cfg_data    = '0;
        cfg_count   = '0;
        drdy        = 1'b0;
        drp_do      = '0;
        mmcm_locked = 1'b0;
        for (int a = 0; a < 128; a++) drp_mem[a] = 16'hFFFF;

        repeat (3) @(negedge clk);
        chk("rst_outs", 32'({busy, done, err, mmcm_rst, den, dwe}), 32'd0);
        chk("rst_bus", 32'({daddr, di}), 32'd0);
        rst_n = 1'b1;

        // Single entry, merge against all-ones register.
        load_entry(0, 7'h08, 16'h1000, 16'h0145);
        run_seq("t1", 1, 2, -1, 3, 1'b0);
        got = (wr_log.size() > 0) ? 32'(wr_log[0][15:0]) : 32'hDEADBEEF;
        chk("t1_di", 32'(got), 32'h1145);

        // Three entries, full overwrite, index order.
        load_entry(0, 7'h08, 16'h0000, 16'hAAAA);
        load_entry(1, 7'h09, 16'h0000, 16'hAAAA);
        load_entry(2, 7'h14, 16'h0000, 16'hAAAA);
        run_seq("t2", 3, 2, -1, 4, 1'b0);

        bad_start("cnt0", 0);
        bad_start("cnt9", 9);

        // Second entry's read never answered.
        run_seq("hang", 3, 2, 1, 3, 1'b0);

        // Lock never arrives; then a valid run clears err.
        run_seq("lockto", 1, 1, -1, 0, 1'b0);
        run_seq("clr", 2, 1, -1, 2, 1'b0);

        // start and table write while busy are ignored.
        run_seq("poke", 2, 3, -1, 2, 1'b1);
        run_seq("poke_chk", 1, 1, -1, 1, 1'b0);

        // Reset in the middle of a write wait.
        lat_cfg  = 3;
        hang_cfg = -1;
        lock_cfg = 3;
        rd_log.delete();
        wr_log.delete();
        @(negedge clk);
        start     = 1'b1;
        cfg_count = 4'd2;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 200 && wr_log.size() == 0; k++) begin
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        chk("mid_busy", 32'({busy, mmcm_rst}), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", 32'({mmcm_rst, den, busy, done}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_idle", 32'({busy, mmcm_rst, den}), 32'd0);
        run_seq("after_rst", 2, 2, -1, 2, 1'b0);

        // Randomized tables, DRP latencies and lock times.
        for (int a = 0; a < 128; a++) drp_mem[a] = 16'($urandom);
        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(1, DEPTH));
            for (int i = 0; i < n; i++)
                load_entry(i, 7'($urandom_range(0, 127)), 16'($urandom), 16'($urandom));
            run_seq($sformatf("rnd%0d", r), n, int'($urandom_range(1, 4)), -1,
                    int'($urandom_range(1, 10)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
